rr_mux_sequencer: RTL
=====================

// Module: rr_mux_sequencer
// PURPOSE
//  Round-robin sequencer that drives the 3-bit select of the 8:1 data mux and consumes its output.
//  Arbitrates 8 request lines and steers the mux to the winning lane.
//  Captures the selected word and presents it downstream with a valid/ready handshake.
//  Sits between the 8 producer lanes and the downstream consumer, wrapped around the combinational mux8to1.
// PARAMETERS
//  N  default 8  data width of each mux lane and of out_data
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous active-high reset
//  req        in   8      per-lane request; lane i holds its data stable while grant[i]=1
//  mux_y      in   N      output of the 8:1 mux (y), driven by sel
//  sel        out  3      mux select (s); registered
//  grant      out  8      one-hot grant to the lane being transferred; registered
//  out_data   out  N      captured lane data
//  out_valid  out  1      out_data valid
//  out_ready  in   1      consumer accepts out_data when out_valid && out_ready at a rising edge
//  xfer_cnt   out  16     completed transfers; present only with RR_XFER_COUNT_EN
// BEHAVIOUR
//  Interface: one clock (clk); reset (rst) is synchronous and active-high.
//  Reset values: sel=0, grant=0, out_data=0, out_valid=0, ptr=0, state=IDLE (and xfer_cnt=0 when enabled).
//  ptr (3b) = highest-priority lane; search order is ptr, ptr+1, ... mod 8.
//  FSM states: IDLE, SETTLE, HOLD.
//   IDLE: if req==0, stay; sel holds its last value and grant=0.
//         Else sel<=first requesting lane in search order, grant<=1<<that lane, go to SETTLE.
//   SETTLE: one cycle for mux_y to follow sel. At exit: out_data<=mux_y, out_valid<=1, go to HOLD.
//   HOLD: out_valid=1; out_data, sel and grant stay stable.
//         On an edge with out_ready=1: out_valid<=0, grant<=0, ptr<=sel+1 (7 wraps to 0), go to IDLE.
//  Latency: req sampled at edge k -> sel/grant valid after k+1 -> out_valid after k+2.
//  Throughput: at most 1 transfer per 3 cycles.
//  req deassert mid-transfer: ignored; the transfer completes.
//  out_ready=1 while out_valid=0: ignored.
//  out_ready is high in the same cycle out_valid first rises: handshake completes at the next edge.
//  rst asserted in any state: the in-flight transfer is discarded; all reset values apply at that edge.
//  Fairness: a lane that is continuously requesting waits at most 7 other transfers.
// CONFIGURATION
//  RR_XFER_COUNT_EN defined:
//   xfer_cnt increments by 1 on each completed handshake; wraps from 16'hFFFF to 0; cleared by rst.
//  RR_XFER_COUNT_EN undefined:
//   xfer_cnt port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package rr_mux_pkg:
//   NCH=8, SEL_W=3, state encoding localparams (IDLE=2'd0, SETTLE=2'd1, HOLD=2'd2).
//  Sub-module rr_pick8 (combinational):
//   inputs req[7:0], ptr[2:0]; outputs any, idx[2:0].
//   Implementation: rotate req right by ptr, priority-encode, add ptr mod 8.
//  Top level: FSM, ptr register, capture register, optional counter.
//  The mux8to1 is instantiated by the enclosing design/bench, not inside this block.
// TESTING (bench instantiates rr_mux_sequencer + mux8to1, N=8)
//  Lane data: i0..i7 = AA,BB,CC,DD,EE,FF,11,22.
//  1 Reset: rst=1 for 2 cycles
//    -> sel=0, grant=0, out_valid=0, out_data=00.
//  2 Single request: req=8'h20, out_ready=1
//    -> sel=5 and grant=8'h20 after 1 cycle; out_valid=1 with out_data=FF after 2 cycles;
//       grant=0 after the handshake.
//  3 All requesting: req=8'hFF, out_ready=1
//    -> grant order 0,1,...,7,0; out_data sequence AA,BB,CC,DD,EE,FF,11,22,AA; 3 cycles per word.
//  4 Backpressure: req=8'h08, out_ready=0 for 5 cycles, then 1
//    -> out_valid=1, out_data=DD, sel=3 all held stable; the transfer completes 1 edge after ready rises.
//  5 Wrap and fairness: after lane 7 is granted, req=8'h81
//    -> lane 0 is granted next, then lane 7.
//  6 Reset mid-HOLD: rst=1 while out_valid=1
//    -> next edge: out_valid=0, grant=0, ptr=0.
//    With RR_XFER_COUNT_EN: xfer_cnt=0 after reset and equals 9 after scenario 3.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared constants, FSM state type and helpers for the round-robin mux sequencer.
package rr_mux_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  function automatic logic [NCH-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
    return NCH'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8to1.sv
// Combinational 8:1 data mux steered by the sequencer's select; zero latency, no flow control.
module mux8to1 #(
  parameter int N = 8
) (
  input  logic [N-1:0] i0,
  input  logic [N-1:0] i1,
  input  logic [N-1:0] i2,
  input  logic [N-1:0] i3,
  input  logic [N-1:0] i4,
  input  logic [N-1:0] i5,
  input  logic [N-1:0] i6,
  input  logic [N-1:0] i7,
  input  logic [2:0]   s,
  output logic [N-1:0] y
);

  always_comb begin
    y = i0;
    case (s)
      3'd0: y = i0;
      3'd1: y = i1;
      3'd2: y = i2;
      3'd3: y = i3;
      3'd4: y = i4;
      3'd5: y = i5;
      3'd6: y = i6;
      3'd7: y = i7;
      default: y = i0;
    endcase
  end

endmodule

// File: rtl/rr_mux_sequencer_pick.sv
// rr_pick8: combinational round-robin pick of the first requesting lane at or after ptr.
module rr_pick8
  import rr_mux_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  logic [SEL_W-1:0] off;

  // Rotating right by ptr puts lane ptr at bit 0, so the lowest set bit is the winner.
  assign dbl = {req, req};
  assign rot = NCH'(dbl >> ptr);

  always_comb begin
    off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign any = |req;
  assign idx = ptr + off;

endmodule

// File: rtl/rr_mux_sequencer.sv
// Round-robin sequencer: arbitrates 8 lanes, steers the external 8:1 mux, captures its output;
// req->out_valid in 2 cycles, holds word until out_ready. Optional xfer_cnt via RR_XFER_COUNT_EN.
module rr_mux_sequencer
  import rr_mux_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic [N-1:0]     mux_y,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   grant,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef RR_XFER_COUNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [SEL_W-1:0] sel_n;
  logic [NCH-1:0]   grant_n;
  logic [N-1:0]     out_data_n;
  logic             out_valid_n;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    sel_n       = sel;
    grant_n     = grant;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    case (state)
      IDLE: begin
        if (pick_any) begin
          sel_n   = pick_idx;
          grant_n = lane_onehot(pick_idx);
          state_n = SETTLE;
        end
      end
      // The mux has had a full cycle to follow sel, so its output is safe to capture.
      SETTLE: begin
        out_data_n  = mux_y;
        out_valid_n = 1'b1;
        state_n     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          grant_n     = '0;
          ptr_n       = sel + SEL_W'(1);
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      grant     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      sel       <= sel_n;
      grant     <= grant_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
    end
  end

`ifdef RR_XFER_COUNT_EN
  logic        done;
  logic [15:0] cnt;

  assign done = (state == HOLD) && out_ready;

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (done) cnt <= cnt + 16'd1;
  end

  assign xfer_cnt = cnt;
`endif

endmodule
